// File: rtl/dualram_sweep.sv
// Simple dual-port RAM with one write port, one registered read port and a selectable read-during-write policy.
// Contents are never reset. A sweep FSM writes INIT_VAL to every location after reset or on clr.
module dualram_sweep #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 3,
  parameter int                 BYPASS   = 1,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              as_clr_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              busy,
  output logic              wr_drop
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_dout;
  logic                r_rd_valid, r_wr_drop;

  logic                w_wr_ok, w_rd_en, w_drop, w_mem_we, w_bypass;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_din;

  always_ff @(posedge clk or negedge as_clr_n) begin
    if (!as_clr_n) r_state <= S_INIT;
    else           r_state <= w_next;
  end

  // clr takes priority over sweep completion so a late clear still gets a full sweep
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT: if (!clr && r_cnt == ADDR_W'(DEPTH - 1)) w_next = S_IDLE;
      S_IDLE: if (clr) w_next = S_INIT;
      default: w_next = S_INIT;
    endcase
  end

  always_comb begin
    busy       = (r_state == S_INIT);
    w_wr_ok    = !busy && we && !clr;
    w_rd_en    = !busy && re;
    w_drop     = we && (busy || clr);
    // Sweep writes are held off while reset is asserted so reset never disturbs contents
    w_mem_we   = (busy && as_clr_n) || w_wr_ok;
    w_mem_addr = busy ? r_cnt : wr_addr;
    w_mem_din  = busy ? INIT_VAL : din;
    w_bypass   = (BYPASS != 0) && w_wr_ok && (wr_addr == rd_addr);
  end

  always_ff @(posedge clk or negedge as_clr_n) begin
    if (!as_clr_n)  r_cnt <= '0;
    else if (clr)   r_cnt <= '0;
    else if (busy)  r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_din;
  end

  always_ff @(posedge clk or negedge as_clr_n) begin
    if (!as_clr_n) begin
      r_dout     <= '0;
      r_rd_valid <= 1'b0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      r_wr_drop  <= w_drop;
      if (w_rd_en) r_dout <= w_bypass ? din : r_mem[rd_addr];
    end
  end

  assign dout     = r_dout;
  assign rd_valid = r_rd_valid;
  assign wr_drop  = r_wr_drop;
endmodule

// File: tb/tb_dualram_sweep.sv
// Directed bench for dualram_sweep: a BYPASS=1 and a BYPASS=0 instance share stimulus.
// Expected read data goes into per-instance queues; a monitor pops them whenever rd_valid rises.
module tb_dualram_sweep;
  logic        clk = 1'b0;
  logic        as_clr_n, clr, we, re;
  logic [2:0]  wr_addr, rd_addr;
  logic [15:0] din;
  logic [15:0] dout1, dout0;
  logic        rv1, rv0, busy1, busy0, wd1, wd0;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] q1[$];
  logic [15:0] q0[$];

  always #5 clk = ~clk;

  dualram_sweep #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .INIT_VAL(16'h0000)) u_dut1 (
    .clk(clk), .as_clr_n(as_clr_n), .clr(clr), .we(we), .wr_addr(wr_addr), .din(din),
    .re(re), .rd_addr(rd_addr), .dout(dout1), .rd_valid(rv1), .busy(busy1), .wr_drop(wd1));

  dualram_sweep #(.DATA_W(16), .ADDR_W(3), .BYPASS(0), .INIT_VAL(16'h0000)) u_dut0 (
    .clk(clk), .as_clr_n(as_clr_n), .clr(clr), .we(we), .wr_addr(wr_addr), .din(din),
    .re(re), .rd_addr(rd_addr), .dout(dout0), .rd_valid(rv0), .busy(busy0), .wr_drop(wd0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_len(output int n);
    n = 0;
    while ((busy1 || busy0) && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e1, input logic [15:0] e0);
    re = 1'b1; rd_addr = a;
    q1.push_back(e1); q0.push_back(e0);
    tick();
    re = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    we = 1'b1; wr_addr = a; din = d;
    tick();
    we = 1'b0;
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rv1) begin
      n_chk++;
      if (q1.size() == 0) begin
        n_fail++; $display("FAIL rd_valid_byp: unexpected read data 0x%0h, none expected", dout1);
      end else begin
        logic [15:0] e;
        e = q1.pop_front();
        if (dout1 !== e) begin n_fail++; $display("FAIL dout_byp: got 0x%0h expected 0x%0h at %0t", dout1, e, $time); end
      end
    end
    if (rv0) begin
      n_chk++;
      if (q0.size() == 0) begin
        n_fail++; $display("FAIL rd_valid_old: unexpected read data 0x%0h, none expected", dout0);
      end else begin
        logic [15:0] e;
        e = q0.pop_front();
        if (dout0 !== e) begin n_fail++; $display("FAIL dout_old: got 0x%0h expected 0x%0h at %0t", dout0, e, $time); end
      end
    end
  end

  initial begin
    int n;
    as_clr_n = 1'b0; clr = 0; we = 0; re = 0; wr_addr = 0; rd_addr = 0; din = 0;
    #2;
    chk("rst_dout", {dout1, dout0}, 32'h0);
    chk("rst_rd_valid", {rv1, rv0}, 0);
    chk("rst_busy", {busy1, busy0}, 2'b11);
    chk("rst_wr_drop", {wd1, wd0}, 0);

    // Release; write attempted during sweep must be dropped
    @(negedge clk); as_clr_n = 1'b1;
    wr(3'd2, 16'hBEEF);
    chk("drop_pulse", {wd1, wd0}, 2'b11);
    tick();
    chk("drop_once", {wd1, wd0}, 2'b00);
    sweep_len(n);
    chk("init_busy_edges", n + 2, 8);
    chk("idle_busy", {busy1, busy0}, 2'b00);

    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, 16'h0000);
    tick();
    chk("rd_valid_clear", {rv1, rv0}, 0);

    wr(3'd5, 16'hA5A5);
    rd(3'd5, 16'hA5A5, 16'hA5A5);
    tick();
    chk("rd_valid_one_cycle", {rv1, rv0}, 0);

    // Same-address collision
    wr(3'd3, 16'h1111);
    we = 1'b1; wr_addr = 3'd3; din = 16'h2222;
    rd(3'd3, 16'h2222, 16'h1111);
    we = 1'b0;
    rd(3'd3, 16'h2222, 16'h2222);
    // Different-address collision
    we = 1'b1; wr_addr = 3'd6; din = 16'h6666;
    rd(3'd5, 16'hA5A5, 16'hA5A5);
    we = 1'b0;
    rd(3'd6, 16'h6666, 16'h6666);

    // Fill, then clr with a same-cycle write and read
    for (int a = 0; a < 8; a++) wr(3'(a), 16'hFFFF);
    clr = 1'b1; we = 1'b1; wr_addr = 3'd0; din = 16'h1234;
    rd(3'd7, 16'hFFFF, 16'hFFFF);
    clr = 1'b0; we = 1'b0;
    chk("clr_wr_drop", {wd1, wd0}, 2'b11);
    chk("clr_busy", {busy1, busy0}, 2'b11);
    re = 1'b1; rd_addr = 3'd1;  // ignored while sweeping
    sweep_len(n);
    re = 1'b0;
    chk("clr_busy_edges", n, 8);
    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, 16'h0000);

    // Reset during a read
    wr(3'd4, 16'hCAFE);
    re = 1'b1; rd_addr = 3'd4;
    tick();
    re = 1'b0;
    chk("pre_rst_dout", dout1, 16'hCAFE);
    as_clr_n = 1'b0;
    #1;
    chk("rst_mid_read_dout", {dout1, dout0}, 32'h0);
    chk("rst_mid_read_valid", {rv1, rv0}, 0);
    chk("rst_mid_read_busy", {busy1, busy0}, 2'b11);

    // Reset in the middle of a sweep
    @(negedge clk); as_clr_n = 1'b1;
    tick(); tick(); tick();
    as_clr_n = 1'b0;
    #1;
    chk("rst_mid_sweep_busy", {busy1, busy0}, 2'b11);
    tick();
    @(negedge clk); as_clr_n = 1'b1;
    sweep_len(n);
    chk("restart_busy_edges", n, 8);
    rd(3'd4, 16'h0000, 16'h0000);
    tick(); tick();
    chk("q_drained", q1.size() + q0.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
